// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer.
// A preset is loaded (digits above 9 are clamped to 9) and then decremented
// once every TICK_DIV clocks while running, with borrows rippling upward from
// digit 0. When the count reaches zero the timer stops and pulses done once.
module bcd_countdown #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] cnt,
  output logic                    dec_tick,
  output logic                    running,
  output logic                    zero,
  output logic                    done
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt,   w_cnt;
  logic [PW-1:0]   r_pre,   w_pre;
  logic            r_tick,  w_tick;
  logic            r_done,  w_done;
  logic [CW-1:0]   w_dec;

  // Force every digit of a preset into the legal BCD range 0..9.
  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Digit-wise BCD decrement: a digit moves only while every lower digit
  // was zero; a zero digit that moves wraps to 9.
  function automatic logic [CW-1:0] dec_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_dec = dec_bcd(r_cnt);

  // Next-state and next-value logic; load beats pause beats start.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pre   = r_pre;
    w_tick  = 1'b0;
    w_done  = 1'b0;
    if (load) begin
      w_cnt   = clamp_bcd(load_val);
      w_pre   = '0;
      w_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (r_cnt == '0) begin
              w_state = DONE;
              w_done  = 1'b1;
            end else begin
              w_state = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            w_state = PAUSED;
          end else if (r_pre == PRE_LAST) begin
            w_pre  = '0;
            w_cnt  = w_dec;
            w_tick = 1'b1;
            if (w_dec == '0) begin
              w_state = DONE;
              w_done  = 1'b1;
            end
          end else begin
            w_pre = r_pre + PW'(1);
          end
        end
        PAUSED: begin
          if (!pause && start) w_state = RUN;
        end
        default: begin
          w_state = DONE;
        end
      endcase
    end
  end

  // State, count, prescaler and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_pre   <= w_pre;
      r_tick  <= w_tick;
      r_done  <= w_done;
    end
  end

  assign cnt      = r_cnt;
  assign dec_tick = r_tick;
  assign done     = r_done;
  assign running  = (r_state == RUN);
  assign zero     = (r_cnt == '0);

endmodule
